// File: rtl/spi_target_pkg.sv
// Shared types for the SPI target endpoint.
//   byte_t    : one SPI data byte
//   bit_cnt_t : position within the current byte (wraps 7 -> 0)
//   state_t   : link state, idle (deselected) or active (selected)
package spi_target_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef logic [BYTE_W-1:0]    byte_t;
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with optional edge detect.
//   clock, reset_n : system clock, async active-low reset
//   din            : asynchronous input
//   level          : synchronized level (SYNC_STAGES clocks behind din)
//   rise_c, fall_c : combinational one-cycle edge strobes of level (0 when EDGES=0)
// RESET_VAL sets the value the chain (and edge history) assumes in reset.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0,
    parameter bit          EDGES       = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Synchronizer chain, din enters at bit 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];

    generate
        if (EDGES) begin : g_edges
            logic prev_q;

            // Previous synchronized value for edge detection
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    prev_q <= RESET_VAL;
                end else begin
                    prev_q <= level;
                end
            end

            assign rise_c = level & ~prev_q;
            assign fall_c = ~level & prev_q;
        end else begin : g_no_edges
            assign rise_c = 1'b0;
            assign fall_c = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_target.sv
// SPI target endpoint, mode 0 (CPOL=0, CPHA=0), 8-bit, LSB-first.
// SCK/MOSI/SS_n are oversampled in the system clock domain.
//   clock, reset_n        : system clock, async active-low reset
//   spi_sck/mosi/ss_n     : SPI link from the master (ss_n may be tied low)
//   spi_miso, spi_miso_oe : target-out data and its enable (= selected)
//   rx_data/valid/ready   : received-byte stream
//   tx_data/valid/ready   : transmit-byte stream into a one-byte holding register
//   overrun, underrun     : sticky error flags, cleared by clr_flags (set wins)
//   busy                  : mid-byte indicator
// Build option: SPI_TARGET_LOOPBACK_EN echoes the last received byte instead of
// FILL_BYTE when the transmit holding register is empty at a reload.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter byte_t       FILL_BYTE   = 8'hFF
) (
    input  logic  clock,
    input  logic  reset_n,
    input  logic  spi_sck,
    input  logic  spi_mosi,
    input  logic  spi_ss_n,
    output logic  spi_miso,
    output logic  spi_miso_oe,
    output byte_t rx_data,
    output logic  rx_valid,
    input  logic  rx_ready,
    input  byte_t tx_data,
    input  logic  tx_valid,
    output logic  tx_ready,
    output logic  overrun,
    output logic  underrun,
    input  logic  clr_flags,
    output logic  busy
);

    logic sck_rise;
    logic sck_fall;
    logic sck_lvl_unused;
    logic mosi_lvl;
    logic mosi_rise_unused;
    logic mosi_fall_unused;
    logic ss_lvl;
    logic ss_rise_unused;
    logic ss_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGES(1'b1)) u_sync_sck (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (spi_sck),
        .level  (sck_lvl_unused),
        .rise_c (sck_rise),
        .fall_c (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGES(1'b0)) u_sync_mosi (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (spi_mosi),
        .level  (mosi_lvl),
        .rise_c (mosi_rise_unused),
        .fall_c (mosi_fall_unused)
    );

    // ss_n resets deselected so a tied-low select produces a clean entry into ACTIVE
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGES(1'b0)) u_sync_ss (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (spi_ss_n),
        .level  (ss_lvl),
        .rise_c (ss_rise_unused),
        .fall_c (ss_fall_unused)
    );

    state_t   state_q,   state_d;
    bit_cnt_t bit_cnt_q, bit_cnt_d;
    // Only the upper 7 bits of the receive shifter are ever needed: bit 0 falls out on the completing edge
    logic [BYTE_W-2:0] rx_shift_q, rx_shift_d;
    byte_t    tx_shift_q, tx_shift_d;
    byte_t    hold_q,     hold_d;
    byte_t    rx_data_d;
    logic     rx_valid_d, tx_ready_d, overrun_d, underrun_d, busy_d, miso_d, miso_oe_d;
`ifdef SPI_TARGET_LOOPBACK_EN
    byte_t    last_rx_q,  last_rx_d;
`endif

    byte_t    rx_byte;
    byte_t    fill_src;
    logic     reload;
    logic     select_load;

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        rx_data_d   = rx_data;
        rx_valid_d  = rx_valid;
        tx_ready_d  = tx_ready;
        overrun_d   = overrun;
        underrun_d  = underrun;
        miso_d      = spi_miso;
        reload      = 1'b0;
        select_load = 1'b0;
        rx_byte     = {mosi_lvl, rx_shift_q};
`ifdef SPI_TARGET_LOOPBACK_EN
        last_rx_d   = last_rx_q;
        // Completing edge echoes the byte landing now; selection echoes the previous one
        fill_src    = (state_q == ST_ACTIVE) ? rx_byte : last_rx_q;
`else
        fill_src    = FILL_BYTE;
`endif

        if (rx_valid && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (tx_valid && tx_ready) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end
        if (clr_flags) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (!ss_lvl) begin
                    state_d     = ST_ACTIVE;
                    reload      = 1'b1;
                    select_load = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_lvl) begin
                    // Deselect drops any partial byte
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (sck_rise) begin
                    rx_shift_d = rx_byte[BYTE_W-1:1];
                    bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == '1) begin
                        reload = 1'b1;
`ifdef SPI_TARGET_LOOPBACK_EN
                        last_rx_d = rx_byte;
`endif
                        if (!rx_valid || rx_ready) begin
                            rx_data_d  = rx_byte;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (sck_fall) begin
                    // First fall after a byte boundary presents the freshly reloaded bit 0
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = tx_shift_q >> 1;
                        miso_d     = tx_shift_q[1];
                    end else begin
                        miso_d     = tx_shift_q[0];
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // Reload sees the holding register as it was before any same-cycle load
        if (reload) begin
            if (!tx_ready) begin
                tx_shift_d = hold_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d = fill_src;
                underrun_d = 1'b1;
            end
        end
        if (select_load) begin
            miso_d = tx_shift_d[0];
        end

        miso_oe_d = (state_d == ST_ACTIVE);
        busy_d    = (bit_cnt_d != '0);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= FILL_BYTE;
            hold_q      <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b1;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            busy        <= 1'b0;
            spi_miso    <= FILL_BYTE[0];
            spi_miso_oe <= 1'b0;
`ifdef SPI_TARGET_LOOPBACK_EN
            last_rx_q   <= FILL_BYTE;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            rx_data     <= rx_data_d;
            rx_valid    <= rx_valid_d;
            tx_ready    <= tx_ready_d;
            overrun     <= overrun_d;
            underrun    <= underrun_d;
            busy        <= busy_d;
            spi_miso    <= miso_d;
            spi_miso_oe <= miso_oe_d;
`ifdef SPI_TARGET_LOOPBACK_EN
            last_rx_q   <= last_rx_d;
`endif
        end
    end

endmodule
